trackball_counter: RTL and testbench
====================================

TRACKBALL_COUNTER -- requirements
Module: trackball_counter

Interface
REQ-001 Parameter CNT_W, default 4: width of each axis position counter.
REQ-002 Parameter FILT_LEN, default 4: number of consecutive stable samples a quadrature input needs before it is accepted; legal range 2..15.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 h_clk  input  1  horizontal quadrature clock, asynchronous to clk.
REQ-006 h_dir  input  1  horizontal direction (1 = increment), asynchronous.
REQ-007 v_clk  input  1  vertical quadrature clock, asynchronous.
REQ-008 v_dir  input  1  vertical direction (1 = increment), asynchronous.
REQ-009 flip  input  1  cocktail flip; 1 inverts both effective directions.
REQ-010 snap  input  1  one-cycle strobe that captures both axes atomically into the read registers.
REQ-011 h_data_o  output  8  {h_dir_latched, (7-CNT_W) zeros, h_count_snapshot}.
REQ-012 v_data_o  output  8  {v_dir_latched, (7-CNT_W) zeros, v_count_snapshot}.
REQ-013 h_edge_o  output  1  one-cycle pulse for each accepted horizontal count event.
REQ-014 v_edge_o  output  1  one-cycle pulse for each accepted vertical count event.

Function
REQ-015 Each of h_clk, h_dir, v_clk, v_dir SHALL pass through a two-flop synchronizer before any other use.
REQ-016 A count event SHALL be declared on a synchronized 0->1 transition of the axis clock.
REQ-017 The count event SHALL update the live counter on the clock after the synchronized edge; total input-to-live-counter latency is 3 clk cycles when the filter is compiled out.
REQ-018 Effective direction SHALL be dir XOR flip, sampled on the same cycle the event is declared.
REQ-019 On a count event, the live counter SHALL increment if the effective direction is 1 and decrement if it is 0.
REQ-020 The live counter SHALL wrap modulo 2^CNT_W: all-ones+1 -> 0, and 0-1 -> all-ones.
REQ-021 On a count event, the direction-latch bit SHALL be loaded with the effective direction; otherwise it holds.
REQ-022 The edge pulse (h_edge_o or v_edge_o) SHALL assert in the same cycle the live counter updates.
REQ-023 On snap=1, both live counters and both direction latches SHALL be copied into the output registers on the same clock edge.
REQ-024 Snap and a count event in the same cycle: the snapshot SHALL capture the pre-update value, and the live counter SHALL still update.
REQ-025 With snap=0, h_data_o and v_data_o SHALL hold their values.
REQ-026 A direction change with no clock edge SHALL alter neither the counter nor the latch.
REQ-027 The horizontal and vertical axes SHALL be fully independent; simultaneous events on both axes SHALL both be counted.

Reset
REQ-028 Asserting reset SHALL immediately clear all of the following to 0, without waiting for clk:
- synchronizers and filter state;
- live counters and direction latches;
- h_data_o and v_data_o;
- h_edge_o and v_edge_o.
REQ-029 After reset deasserts, a synchronized clock input that is already high SHALL NOT produce a count event; it must first go low.
REQ-030 Reset asserted mid-event SHALL discard the pending event.

Configuration
REQ-031 The macro TRACKBALL_COUNTER_FILTER_EN SHALL control the glitch filter.
REQ-032 With TRACKBALL_COUNTER_FILTER_EN defined:
- each synchronized clock input feeds a per-axis stability counter;
- the filtered level changes only after FILT_LEN consecutive samples differ from it;
- count events use the filtered level;
- latency grows by FILT_LEN cycles.
REQ-033 Without TRACKBALL_COUNTER_FILTER_EN, the synchronized level SHALL drive edge detection directly; FILT_LEN is ignored.

Verification
REQ-034 Five rising edges on h_clk with h_dir=1, flip=0, then snap -> h_data_o=8'h85, v_data_o=8'h00.
REQ-035 Live v count at 0, one v_clk edge with v_dir=0, then snap -> v_data_o=8'h0F (wrap); sixteen more decrement edges, then snap -> 8'h0F again.
REQ-036 flip=1, three h_clk edges with h_dir=1, then snap -> h_data_o=8'h0D.
REQ-037 Live h count at 3; snap issued in the same cycle as the count event -> h_data_o low nibble=3; next snap -> 4.
REQ-038 With the filter compiled in (FILT_LEN=4): a 2-cycle h_clk high glitch -> no count and no h_edge_o; a 6-cycle pulse -> exactly one count.
REQ-039 Reset asserted while h_clk is held high, then released with h_clk still high -> no count until h_clk returns low and rises again.

Source files
------------

// File: rtl/trackball_counter.sv
// rtl/trackball_counter.sv - two-axis quadrature trackball position counter with atomic snapshot
//
// trackball_counter: top level; two independent axis counters sharing flip and snap.
//   Parameters
//     CNT_W     width of each axis position counter (1..7)
//     FILT_LEN  consecutive stable samples needed by the glitch filter (2..15)
//   Ports
//     clk                system clock, rising edge
//     reset              asynchronous active-high reset
//     h_clk / h_dir      horizontal quadrature clock / direction (async)
//     v_clk / v_dir      vertical quadrature clock / direction (async)
//     flip               inverts both effective directions
//     snap               one-cycle strobe capturing both axes into h_data_o / v_data_o
//     h_data_o/v_data_o  {direction latch, zero pad, counter snapshot}
//     h_edge_o/v_edge_o  one-cycle pulse per accepted count event
//   Build option
//     TRACKBALL_COUNTER_FILTER_EN  when defined, each synchronized axis clock passes
//                                  through a FILT_LEN-sample stability filter.
//
// trackball_counter_axis: one axis (synchronizers, optional filter, edge detect,
//   live counter, direction latch, snapshot register).

module trackball_counter_axis #(
    parameter int CNT_W    = 4,
    parameter int FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       q_clk,
    input  logic       q_dir,
    input  logic       flip,
    input  logic       snap,
    output logic       edge_pulse,
    output logic [7:0] data
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // [0] is the metastability stage, [1] is the usable synchronized level
    logic [1:0] clk_sync;
    logic [1:0] dir_sync;
    // Shifts in ones after reset; full once the synchronizers hold real samples
    logic [1:0] sync_fill;

    logic             clk_s;
    logic             dir_s;
    logic             sync_full;
    logic             lvl;
    logic             lvl_q;
    logic             armed;
    logic             count_event;
    logic             eff_dir;
    logic [CNT_W-1:0] live_cnt;
    logic             dir_latch;
    logic [CNT_W-1:0] snap_cnt;
    logic             snap_dir;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b00;
            dir_sync  <= 2'b00;
            sync_fill <= 2'b00;
        end else begin
            clk_sync  <= {clk_sync[0], q_clk};
            dir_sync  <= {dir_sync[0], q_dir};
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

    assign clk_s     = clk_sync[1];
    assign dir_s     = dir_sync[1];
    assign sync_full = sync_fill[1];

`ifdef TRACKBALL_COUNTER_FILTER_EN
    // The filtered level only follows clk_s after FILT_LEN consecutive
    // samples disagree with it; any agreeing sample restarts the count.
    logic       filt_lvl;
    logic [3:0] stab_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_lvl <= 1'b0;
            stab_cnt <= 4'd0;
        end else if (clk_s == filt_lvl) begin
            stab_cnt <= 4'd0;
        end else if (stab_cnt == 4'(FILT_LEN - 1)) begin
            filt_lvl <= clk_s;
            stab_cnt <= 4'd0;
        end else begin
            stab_cnt <= stab_cnt + 4'd1;
        end
    end

    assign lvl = filt_lvl;
`else
    assign lvl = clk_s;
`endif

    // An input that is already high when reset releases must not count:
    // edges are ignored until the level has been genuinely observed low.
    assign count_event = lvl & ~lvl_q & armed;
    assign eff_dir     = dir_s ^ flip;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_q      <= 1'b0;
            armed      <= 1'b0;
            live_cnt   <= '0;
            dir_latch  <= 1'b0;
            edge_pulse <= 1'b0;
            snap_cnt   <= '0;
            snap_dir   <= 1'b0;
        end else begin
            lvl_q      <= lvl;
            edge_pulse <= count_event;
            if (sync_full && !clk_s && !lvl) begin
                armed <= 1'b1;
            end
            if (count_event) begin
                live_cnt  <= eff_dir ? (live_cnt + CNT_ONE) : (live_cnt - CNT_ONE);
                dir_latch <= eff_dir;
            end
            // Sees pre-update live values when a count event lands on the same edge
            if (snap) begin
                snap_cnt <= live_cnt;
                snap_dir <= dir_latch;
            end
        end
    end

    assign data = {snap_dir, 7'(snap_cnt)};

endmodule

module trackball_counter #(
    parameter int CNT_W    = 4,
    parameter int FILT_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_clk,
    input  logic       h_dir,
    input  logic       v_clk,
    input  logic       v_dir,
    input  logic       flip,
    input  logic       snap,
    output logic [7:0] h_data_o,
    output logic [7:0] v_data_o,
    output logic       h_edge_o,
    output logic       v_edge_o
);

    trackball_counter_axis #(
        .CNT_W   (CNT_W),
        .FILT_LEN(FILT_LEN)
    ) u_h_axis (
        .clk       (clk),
        .reset     (reset),
        .q_clk     (h_clk),
        .q_dir     (h_dir),
        .flip      (flip),
        .snap      (snap),
        .edge_pulse(h_edge_o),
        .data      (h_data_o)
    );

    trackball_counter_axis #(
        .CNT_W   (CNT_W),
        .FILT_LEN(FILT_LEN)
    ) u_v_axis (
        .clk       (clk),
        .reset     (reset),
        .q_clk     (v_clk),
        .q_dir     (v_dir),
        .flip      (flip),
        .snap      (snap),
        .edge_pulse(v_edge_o),
        .data      (v_data_o)
    );

endmodule

// File: tb/tb_trackball_counter.sv
// tb/tb_trackball_counter.sv - scoreboard bench for trackball_counter

module tb_trackball_counter;

`ifdef TRACKBALL_COUNTER_FILTER_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = 10;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       h_clk = 1'b0;
    logic       h_dir = 1'b0;
    logic       v_clk = 1'b0;
    logic       v_dir = 1'b0;
    logic       flip  = 1'b0;
    logic       snap  = 1'b0;
    logic [7:0] h_data_o;
    logic [7:0] v_data_o;
    logic       h_edge_o;
    logic       v_edge_o;

    int checks   = 0;
    int failures = 0;
    int h_edges  = 0;
    int v_edges  = 0;

    typedef struct {
        string      name;
        logic [7:0] h;
        logic [7:0] v;
        int         he;
        int         ve;
    } exp_t;

    exp_t exp_q[$];

    trackball_counter #(.CNT_W(4), .FILT_LEN(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .h_clk   (h_clk),
        .h_dir   (h_dir),
        .v_clk   (v_clk),
        .v_dir   (v_dir),
        .flip    (flip),
        .snap    (snap),
        .h_data_o(h_data_o),
        .v_data_o(v_data_o),
        .h_edge_o(h_edge_o),
        .v_edge_o(v_edge_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: one sample per cycle, 1 ns after the rising edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (snap && !reset) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_snap: got snapshot h=0x%0h v=0x%0h with empty scoreboard", h_data_o, v_data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_h_data"}, int'(h_data_o), int'(e.h));
                    chk({e.name, "_v_data"}, int'(v_data_o), int'(e.v));
                    chk({e.name, "_h_edges"}, h_edges, e.he);
                    chk({e.name, "_v_edges"}, v_edges, e.ve);
                end
            end
            if (reset) begin
                h_edges = 0;
                v_edges = 0;
            end else begin
                if (h_edge_o) h_edges++;
                if (v_edge_o) v_edges++;
            end
        end
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input bit do_h, input bit do_v);
        @(negedge clk);
        if (do_h) h_clk = 1'b1;
        if (do_v) v_clk = 1'b1;
        hold(HOLD);
        h_clk = 1'b0;
        v_clk = 1'b0;
        hold(HOLD);
    endtask

    task automatic do_snap(input string nm, input logic [7:0] h, input logic [7:0] v,
                           input int he, input int ve);
        exp_t e;
        @(negedge clk);
        e.name = nm; e.h = h; e.v = v; e.he = he; e.ve = ve;
        exp_q.push_back(e);
        snap = 1'b1;
        @(negedge clk);
        snap = 1'b0;
        hold(2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        hold(2);
        reset = 1'b0;
        hold(3);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        // Reset state, before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("reset_h_data", int'(h_data_o), 0);
        chk("reset_v_data", int'(v_data_o), 0);
        chk("reset_h_edge", int'(h_edge_o), 0);
        chk("reset_v_edge", int'(v_edge_o), 0);
        hold(2);
        reset = 1'b0;
        hold(3);

        // Five increments
        h_dir = 1'b1;
        repeat (5) pulse(1'b1, 1'b0);
        do_snap("five_inc", 8'h85, 8'h00, 5, 0);

        // Asynchronous reset mid-cycle clears outputs immediately
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_h_data", int'(h_data_o), 0);
        chk("async_v_data", int'(v_data_o), 0);
        hold(2);
        reset = 1'b0;
        hold(3);
        do_snap("post_reset", 8'h00, 8'h00, 0, 0);

        // Increment wrap: sixteen increments return to zero
        repeat (16) pulse(1'b1, 1'b0);
        do_snap("inc_wrap", 8'h80, 8'h00, 16, 0);

        // Decrement wrap on the vertical axis
        do_reset();
        h_dir = 1'b0;
        v_dir = 1'b0;
        pulse(1'b0, 1'b1);
        do_snap("v_dec_wrap", 8'h00, 8'h0F, 0, 1);
        repeat (16) pulse(1'b0, 1'b1);
        do_snap("v_dec_wrap16", 8'h00, 8'h0F, 0, 17);

        // Flip inverts direction
        do_reset();
        flip  = 1'b1;
        h_dir = 1'b1;
        repeat (3) pulse(1'b1, 1'b0);
        do_snap("flip_dec", 8'h0D, 8'h00, 3, 0);

        // Direction toggles without clock edges change nothing
        repeat (4) begin
            @(negedge clk);
            h_dir = ~h_dir;
            v_dir = ~v_dir;
            hold(5);
        end
        do_snap("dir_only", 8'h0D, 8'h00, 3, 0);
        flip  = 1'b0;
        h_dir = 1'b1;
        v_dir = 1'b0;

        // Snap in the same cycle as a count event captures the pre-update value
        do_reset();
        repeat (3) pulse(1'b1, 1'b0);
        do_snap("pre_same", 8'h83, 8'h00, 3, 0);
        @(negedge clk);
        h_clk = 1'b1;
        hold(LAT - 1);
        e.name = "snap_same_cycle"; e.h = 8'h83; e.v = 8'h00; e.he = 3; e.ve = 0;
        exp_q.push_back(e);
        snap = 1'b1;
        @(negedge clk);
        snap = 1'b0;
        hold(HOLD);
        h_clk = 1'b0;
        hold(HOLD);
        do_snap("snap_after", 8'h84, 8'h00, 4, 0);

        // Both axes counted together, independent directions
        do_reset();
        h_dir = 1'b1;
        v_dir = 1'b1;
        repeat (2) pulse(1'b1, 1'b1);
        do_snap("both_inc", 8'h82, 8'h82, 2, 2);
        v_dir = 1'b0;
        pulse(1'b1, 1'b1);
        do_snap("both_mixed", 8'h83, 8'h01, 3, 3);

        // Clock held high through reset release does not count
        @(negedge clk);
        h_dir = 1'b1;
        h_clk = 1'b1;
        reset = 1'b1;
        hold(2);
        reset = 1'b0;
        hold(20);
        do_snap("high_at_release", 8'h00, 8'h00, 0, 0);
        h_clk = 1'b0;
        hold(HOLD);
        h_clk = 1'b1;
        hold(HOLD);
        h_clk = 1'b0;
        hold(HOLD);
        do_snap("rearmed", 8'h81, 8'h00, 1, 0);

        // Reset mid-event discards the pending event
        do_reset();
        @(negedge clk);
        h_clk = 1'b1;
        hold(1);
        reset = 1'b1;
        hold(1);
        h_clk = 1'b0;
        hold(2);
        reset = 1'b0;
        hold(20);
        do_snap("reset_mid_event", 8'h00, 8'h00, 0, 0);

`ifdef TRACKBALL_COUNTER_FILTER_EN
        // Short glitch rejected, long pulse counted once
        do_reset();
        h_dir = 1'b1;
        @(negedge clk);
        h_clk = 1'b1;
        hold(2);
        h_clk = 1'b0;
        hold(HOLD);
        do_snap("filt_glitch", 8'h00, 8'h00, 0, 0);
        @(negedge clk);
        h_clk = 1'b1;
        hold(6);
        h_clk = 1'b0;
        hold(HOLD);
        do_snap("filt_pulse", 8'h81, 8'h00, 1, 0);
`endif

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
